// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - 4-requester burst arbiter driving the 4:1 mux selects
module mux_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       mode,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       valid,
    output logic       done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       rr_ptr;
    logic [1:0]       pick;
    logic             found;
    logic [1:0]       idx;
    logic [1:0]       owner;
    logic             burst_end;

    // Winner search: fixed scans 0..3, round-robin scans rr_ptr+1 .. rr_ptr+4 (wrapping).
    always_comb begin
        pick  = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        if (!mode) begin
            for (int k = 0; k < 4; k++) begin
                if (!found && req[k]) begin
                    pick  = k[1:0];
                    found = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                idx = rr_ptr + k[1:0];
                if (!found && req[idx]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
    end

    assign owner     = {s0, s1};
    assign burst_end = (cnt == CNT_LAST) || !req[owner];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= 4'b0000;
            s0     <= 1'b0;
            s1     <= 1'b0;
            valid  <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            rr_ptr <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt    <= 4'b0001 << pick;
                        s0     <= pick[1];
                        s1     <= pick[0];
                        valid  <= 1'b1;
                        cnt    <= '0;
                        rr_ptr <= pick;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    // Selects are left on the last owner so the mux output stays stable.
                    if (burst_end) begin
                        gnt   <= 4'b0000;
                        valid <= 1'b0;
                        done  <= 1'b1;
                        state <= GAP;
                    end
                end
                GAP: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - table-driven bench for mux_arbiter (BURST_LEN 4 and 1 builds)
module tb_mux_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       mode;
    logic [3:0] gnt;
    logic       s0, s1, valid, done;

    logic [3:0] req1;
    logic       mode1;
    logic [3:0] gnt1;
    logic       s0_1, s1_1, valid1, done1;

    int errors = 0;
    int checks = 0;

    mux_arbiter #(.BURST_LEN(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .req(req), .mode(mode),
        .gnt(gnt), .s0(s0), .s1(s1), .valid(valid), .done(done)
    );

    mux_arbiter #(.BURST_LEN(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .mode(mode1),
        .gnt(gnt1), .s0(s0_1), .s1(s1_1), .valid(valid1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       mode;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic r_flag, input logic [3:0] r, input logic m,
                       input logic [3:0] g, input logic [1:0] s, input logic v, input logic d);
        vec_t x;
        x.rst = r_flag; x.req = r; x.mode = m; x.gnt = g; x.sel = s; x.valid = v; x.done = d;
        vecs.push_back(x);
    endtask

    // nvalid valid cycles for owner w, then the done cycle (req = r_end sampled at the end edge), then GAP.
    task automatic add_burst(input logic [3:0] r, input logic m, input int w,
                             input int nvalid, input logic [3:0] r_end);
        logic [1:0] ws;
        logic [3:0] g;
        ws = 2'(w);
        g  = 4'b0001 << ws;
        for (int k = 0; k < nvalid; k++) add(1'b0, r, m, g, ws, 1'b1, 1'b0);
        add(1'b0, r_end, m, 4'b0000, ws, 1'b0, 1'b1);
        add(1'b0, r_end, m, 4'b0000, ws, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; req = 4'b0; mode = 1'b0; req1 = 4'b0; mode1 = 1'b0;

        // Reset, then idle with no requests.
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        // Fixed priority, req=1010: input 1 wins twice, input 3 starves.
        add_burst(4'b1010, 1'b0, 1, 4, 4'b1010);
        add_burst(4'b1010, 1'b0, 1, 4, 4'b1010);
        // req drops on the same edge as the last burst cycle: single done.
        add_burst(4'b0010, 1'b0, 1, 4, 4'b0000);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0);

        // Round-robin with all requesting: 0,1,2,3,0.
        add(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        add_burst(4'b1111, 1'b1, 0, 4, 4'b1111);
        add_burst(4'b1111, 1'b1, 1, 4, 4'b1111);
        add_burst(4'b1111, 1'b1, 2, 4, 4'b1111);
        add_burst(4'b1111, 1'b1, 3, 4, 4'b1111);
        add_burst(4'b1111, 1'b1, 0, 4, 4'b1111);

        // Early release from input 2; next RR search starts at 3.
        add(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        add_burst(4'b0100, 1'b1, 2, 2, 4'b0000);
        add_burst(4'b1001, 1'b1, 3, 4, 4'b1001);

        // Mode flips to RR mid-burst: current owner 0 keeps the full burst, next is RR from 0 -> 3.
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(1'b0, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) add(1'b0, 4'b1001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(1'b0, 4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1);
        add(1'b0, 4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        add_burst(4'b1001, 1'b1, 3, 4, 4'b1001);

        #2;
        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                rst = 1'b1;
                req = 4'b0000;
                mode = vecs[i].mode;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end else begin
                req  = vecs[i].req;
                mode = vecs[i].mode;
                @(posedge clk);
                #1;
            end
            chk($sformatf("vec%0d gnt_sel_v_d", i), {gnt, s0, s1, valid, done},
                {vecs[i].gnt, vecs[i].sel, vecs[i].valid, vecs[i].done});
        end

        // Async reset between edges kills a live grant at once, with no done afterwards.
        req = 4'b0000; mode = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req = 4'b1000;
        @(posedge clk); #1;
        chk("async_pre_grant", {gnt, s0, s1, valid, done}, 8'b1000_11_1_0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_rst_clear", {gnt, s0, s1, valid, done}, 8'b0000_00_0_0);
        #1;
        rst = 1'b0;
        req = 4'b0000;
        @(posedge clk); #1;
        chk("async_no_done", {gnt, valid, done}, 6'b0000_0_0);

        // BURST_LEN=1 build: valid 1,0,0 repeating, done after each valid.
        req1 = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            case (k % 3)
                0:       chk($sformatf("bl1_cyc%0d", k), {gnt1, s0_1, s1_1, valid1, done1}, 8'b0001_00_1_0);
                1:       chk($sformatf("bl1_cyc%0d", k), {gnt1, s0_1, s1_1, valid1, done1}, 8'b0000_00_0_1);
                default: chk($sformatf("bl1_cyc%0d", k), {gnt1, s0_1, s1_1, valid1, done1}, 8'b0000_00_0_0);
            endcase
        end
        req1 = 4'b0000;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
